// File: rtl/shared_counters_pkg.sv
// Shared definitions for the shared_counters slice pool.
//   cmd_e      : command codes carried on command_in (110/111 decode as idle)
//   rd_state_e : serial read-out FSM states
package shared_counters_pkg;

   typedef enum logic [2:0] {
      CMD_IDLE         = 3'b000,
      CMD_INCREMENT    = 3'b001,
      CMD_NEW_COUNTER  = 3'b010,
      CMD_DEALLOCATION = 3'b011,
      CMD_LOAD         = 3'b100,
      CMD_READ         = 3'b101
   } cmd_e;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_SEND,
      RD_DONE
   } rd_state_e;

endpackage

// File: rtl/shared_counters_reader.sv
// Serial read-out of one counter, least-significant slice first.
//   clk, rst       : clock, synchronous active-high reset
//   read_cmd       : a read command is present this cycle
//   start          : read of a valid head; accepted only while idle
//   start_idx      : head slice of the counter being read
//   end_idx        : last slice of the counter being read
//   slices         : live slice values, snapshotted on acceptance
//   rdata_out      : streamed slice (0 when not valid)
//   valid_data_out : rdata_out is valid
//   last           : final slice of the stream
module shared_counters_reader
   import shared_counters_pkg::*;
#(
   parameter int n = 10,
   parameter int g = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 read_cmd,
   input  logic                 start,
   input  logic [$clog2(n)-1:0] start_idx,
   input  logic [$clog2(n)-1:0] end_idx,
   input  logic [g-1:0]         slices [n],
   output logic [g-1:0]         rdata_out,
   output logic                 valid_data_out,
   output logic                 last
);

   localparam int IW = $clog2(n);

   rd_state_e       state_q, state_d;
   logic [g-1:0]    snap_q [n];
   logic [IW-1:0]   ptr_q;
   logic [IW-1:0]   end_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RD_IDLE;
         snap_q  <= '{default: '0};
         ptr_q   <= '0;
         end_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == RD_IDLE && start) begin
            snap_q <= slices;
            ptr_q  <= start_idx;
            end_q  <= end_idx;
         end else if (state_q == RD_SEND) begin
            ptr_q <= ptr_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      valid_data_out = 1'b0;
      rdata_out      = '0;
      last           = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (start) state_d = RD_SEND;
         end
         RD_SEND: begin
            valid_data_out = 1'b1;
            rdata_out      = snap_q[ptr_q];
            last           = (ptr_q == end_q);
            if (ptr_q == end_q) state_d = RD_DONE;
         end
         RD_DONE: begin
            // one stream per read assertion: wait for the command to drop
            if (!read_cmd) state_d = RD_IDLE;
         end
         default: state_d = RD_IDLE;
      endcase
   end

endmodule

// File: rtl/shared_counters.sv
// Pool of n g-bit slices grouped into variable-width counters.
//   clk, rst            : clock, synchronous active-high reset
//   command_in          : 000 idle, 001 inc, 010 new, 011 dealloc, 100 load, 101 read
//   id                  : target counter (head slice index)
//   new_counter_size    : requested width in slices for new_counter
//   load_data_in        : load value, LSB-aligned, qualified by valid_load_data
//   data_out            : live value of every slice
//   allocation_id       : new_counter result (all ones on failure)
//   valid_allocation_id : one-cycle pulse qualifying allocation_id
//   rdata_out, valid_data_out, last : serial read stream
module shared_counters
   import shared_counters_pkg::*;
#(
   parameter int n = 10,
   parameter int g = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           command_in,
   input  logic [$clog2(n)-1:0] id,
   input  logic [31:0]          new_counter_size,
   input  logic [63:0]          load_data_in,
   input  logic                 valid_load_data,
   output logic [g-1:0]         data_out [n],
   output logic [$clog2(n):0]   allocation_id,
   output logic                 valid_allocation_id,
   output logic [g-1:0]         rdata_out,
   output logic                 valid_data_out,
   output logic                 last
);

   localparam int IW = $clog2(n);

   cmd_e            cmd;
   logic [g-1:0]    data_q [n];
   logic [g-1:0]    data_n [n];
   logic [n-1:0]    free_q, free_n;
   logic [n-1:0]    head_q, head_n;
   logic [IW:0]     alloc_id_q;
   logic            alloc_v_q;

   logic            id_ok;
   logic [n-1:0]    cnt_mask;
   logic [IW-1:0]   last_idx;
   logic            fit;
   logic [IW-1:0]   fit_start;
   logic [n-1:0]    alloc_mask;

   always_comb begin
      case (command_in)
         3'b001:  cmd = CMD_INCREMENT;
         3'b010:  cmd = CMD_NEW_COUNTER;
         3'b011:  cmd = CMD_DEALLOCATION;
         3'b100:  cmd = CMD_LOAD;
         3'b101:  cmd = CMD_READ;
         default: cmd = CMD_IDLE;
      endcase
   end

   // Extent of the counter headed at id: the run starts at id (if it is a
   // head) and stops at the next head or free slice. Ids >= n never match.
   always_comb begin
      logic run;
      run      = 1'b0;
      id_ok    = 1'b0;
      last_idx = '0;
      cnt_mask = '0;
      for (int unsigned i = 0; i < n; i++) begin
         if (IW'(i) == id) begin
            run   = head_q[i];
            id_ok = head_q[i];
         end else if (head_q[i] || free_q[i]) begin
            run = 1'b0;
         end
         cnt_mask[i] = run;
         if (run) last_idx = IW'(i);
      end
   end

   // First fit: the first slice at which the free-run length reaches the
   // requested size ends the lowest-starting run that fits.
   always_comb begin
      int unsigned runlen;
      runlen     = 0;
      fit        = 1'b0;
      fit_start  = '0;
      alloc_mask = '0;
      for (int unsigned i = 0; i < n; i++) begin
         if (free_q[i]) runlen = runlen + 1;
         else           runlen = 0;
         if (!fit && new_counter_size != 0 && runlen == new_counter_size) begin
            fit       = 1'b1;
            fit_start = IW'(i + 1 - runlen);
         end
      end
      for (int unsigned i = 0; i < n; i++) begin
         alloc_mask[i] = fit && (i >= 32'(fit_start))
                             && ((i - 32'(fit_start)) < new_counter_size);
      end
   end

   always_comb begin
      logic         carry;
      logic [g:0]   sum;
      logic [63:0]  ld;
      int unsigned  off;
      data_n = data_q;
      free_n = free_q;
      head_n = head_q;
      carry  = 1'b1;
      sum    = '0;
      ld     = '0;
      off    = 0;
      case (cmd)
         CMD_INCREMENT: begin
            for (int unsigned i = 0; i < n; i++) begin
               if (id_ok && cnt_mask[i]) begin
                  sum       = {1'b0, data_q[i]} + {{g{1'b0}}, carry};
                  data_n[i] = sum[g-1:0];
                  carry     = sum[g];
               end
            end
         end
         CMD_LOAD: begin
            for (int unsigned i = 0; i < n; i++) begin
               if (id_ok && valid_load_data && cnt_mask[i]) begin
                  ld        = load_data_in >> (off * g);
                  data_n[i] = ld[g-1:0];
                  off       = off + 1;
               end
            end
         end
         CMD_DEALLOCATION: begin
            for (int unsigned i = 0; i < n; i++) begin
               if (id_ok && cnt_mask[i]) begin
                  free_n[i] = 1'b1;
                  head_n[i] = 1'b0;
                  data_n[i] = '0;
               end
            end
         end
         CMD_NEW_COUNTER: begin
            for (int unsigned i = 0; i < n; i++) begin
               if (alloc_mask[i]) begin
                  free_n[i] = 1'b0;
                  head_n[i] = (IW'(i) == fit_start);
                  data_n[i] = '0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q     <= '{default: '0};
         free_q     <= '1;
         head_q     <= '0;
         alloc_id_q <= '0;
         alloc_v_q  <= 1'b0;
      end else begin
         data_q     <= data_n;
         free_q     <= free_n;
         head_q     <= head_n;
         alloc_v_q  <= (cmd == CMD_NEW_COUNTER);
         alloc_id_q <= fit ? {1'b0, fit_start} : '1;
      end
   end

   assign data_out            = data_q;
   assign allocation_id       = alloc_id_q;
   assign valid_allocation_id = alloc_v_q;

   shared_counters_reader #(
      .n (n),
      .g (g)
   ) u_reader (
      .clk            (clk),
      .rst            (rst),
      .read_cmd       (cmd == CMD_READ),
      .start          ((cmd == CMD_READ) && id_ok),
      .start_idx      (id),
      .end_idx        (last_idx),
      .slices         (data_q),
      .rdata_out      (rdata_out),
      .valid_data_out (valid_data_out),
      .last           (last)
   );

endmodule

// File: tb/tb_shared_counters.sv
module tb_shared_counters;

   localparam int N = 10;
   localparam int G = 4;

   localparam logic [2:0] C_IDLE = 3'b000;
   localparam logic [2:0] C_INC  = 3'b001;
   localparam logic [2:0] C_NEW  = 3'b010;
   localparam logic [2:0] C_DEA  = 3'b011;
   localparam logic [2:0] C_LD   = 3'b100;
   localparam logic [2:0] C_RD   = 3'b101;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    command_in;
   logic [3:0]    id;
   logic [31:0]   new_counter_size;
   logic [63:0]   load_data_in;
   logic          valid_load_data;
   logic [G-1:0]  data_out [N];
   logic [4:0]    allocation_id;
   logic          valid_allocation_id;
   logic [G-1:0]  rdata_out;
   logic          valid_data_out;
   logic          last;

   int tests = 0;
   int fails = 0;

   shared_counters #(
      .n (N),
      .g (G)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .command_in          (command_in),
      .id                  (id),
      .new_counter_size    (new_counter_size),
      .load_data_in        (load_data_in),
      .valid_load_data     (valid_load_data),
      .data_out            (data_out),
      .allocation_id       (allocation_id),
      .valid_allocation_id (valid_allocation_id),
      .rdata_out           (rdata_out),
      .valid_data_out      (valid_data_out),
      .last                (last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   cmd;
      logic [3:0]   vid;
      logic [31:0]  size;
      logic [63:0]  ld;
      logic         vld;
      logic         exp_av;
      logic [4:0]   exp_aid;
      logic [39:0]  exp_data;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [39:0] packed_data();
      logic [39:0] p;
      for (int i = 0; i < N; i++) p[i*G +: G] = data_out[i];
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] c, input logic [3:0] i, input logic [31:0] s,
                        input logic [63:0] d, input logic v);
      command_in       = c;
      id               = i;
      new_counter_size = s;
      load_data_in     = d;
      valid_load_data  = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(C_IDLE, 4'd0, 32'd0, 64'd0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin
         @(negedge clk);
         drive(vecs[k].cmd, vecs[k].vid, vecs[k].size, vecs[k].ld, vecs[k].vld);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d alloc_valid", k), 64'(valid_allocation_id), 64'(vecs[k].exp_av));
         if (vecs[k].exp_av)
            check($sformatf("vec%0d alloc_id", k), 64'(allocation_id), 64'(vecs[k].exp_aid));
         check($sformatf("vec%0d data", k), 64'(packed_data()), 64'(vecs[k].exp_data));
      end
      @(negedge clk);
      drive(C_IDLE, 4'd0, 32'd0, 64'd0, 1'b0);
   endtask

   initial begin
      logic [G-1:0] rd_exp [5];
      // phase A: four allocations
      vecs.push_back(vec_t'{C_NEW, 4'd0, 32'd3, 64'd0, 1'b0, 1'b1, 5'd0, 40'h0});
      vecs.push_back(vec_t'{C_NEW, 4'd0, 32'd1, 64'd0, 1'b0, 1'b1, 5'd3, 40'h0});
      vecs.push_back(vec_t'{C_NEW, 4'd0, 32'd4, 64'd0, 1'b0, 1'b1, 5'd4, 40'h0});
      vecs.push_back(vec_t'{C_NEW, 4'd0, 32'd2, 64'd0, 1'b0, 1'b1, 5'd8, 40'h0});
      // phase B: starts from slices 2..0 = 7,7,0 after the increment run
      vecs.push_back(vec_t'{C_DEA, 4'd4, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 40'h0000000770});
      vecs.push_back(vec_t'{C_LD,  4'd0, 32'd0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 5'd0, 40'h0000000AAA});
      vecs.push_back(vec_t'{C_LD,  4'd4, 32'd0, 64'hFFFF, 1'b1, 1'b0, 5'd0, 40'h0000000AAA});
      vecs.push_back(vec_t'{C_INC, 4'd4, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 40'h0000000AAA});
      vecs.push_back(vec_t'{C_INC, 4'd0, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 40'h0000000AAB});
      vecs.push_back(vec_t'{C_LD,  4'd0, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 40'h0000000AAB});
      vecs.push_back(vec_t'{C_INC, 4'd1, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 40'h0000000AAB});
      vecs.push_back(vec_t'{C_INC, 4'd12, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 40'h0000000AAB});
      vecs.push_back(vec_t'{C_NEW, 4'd0, 32'd4, 64'd0, 1'b0, 1'b1, 5'd4, 40'h0000000AAB});
      vecs.push_back(vec_t'{C_NEW, 4'd0, 32'd1, 64'd0, 1'b0, 1'b1, 5'h1F, 40'h0000000AAB});
      vecs.push_back(vec_t'{C_NEW, 4'd0, 32'd0, 64'd0, 1'b0, 1'b1, 5'h1F, 40'h0000000AAB});
      vecs.push_back(vec_t'{C_NEW, 4'd0, 32'd11, 64'd0, 1'b0, 1'b1, 5'h1F, 40'h0000000AAB});
      vecs.push_back(vec_t'{C_LD,  4'd3, 32'd0, 64'hF, 1'b1, 1'b0, 5'd0, 40'h000000FAAB});
      vecs.push_back(vec_t'{C_INC, 4'd3, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 40'h0000000AAB});
      vecs.push_back(vec_t'{C_LD,  4'd4, 32'd0, 64'h12345, 1'b1, 1'b0, 5'd0, 40'h0023450AAB});
      vecs.push_back(vec_t'{C_LD,  4'd8, 32'd0, 64'hFF, 1'b1, 1'b0, 5'd0, 40'hFF23450AAB});
      vecs.push_back(vec_t'{C_INC, 4'd8, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 40'h0023450AAB});
      vecs.push_back(vec_t'{3'b110, 4'd0, 32'd1, 64'd0, 1'b0, 1'b0, 5'd0, 40'h0023450AAB});
      vecs.push_back(vec_t'{C_DEA, 4'd0, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 40'h0023450000});
      vecs.push_back(vec_t'{C_NEW, 4'd0, 32'd2, 64'd0, 1'b0, 1'b1, 5'd0, 40'h0023450000});
      vecs.push_back(vec_t'{C_NEW, 4'd0, 32'd1, 64'd0, 1'b0, 1'b1, 5'd2, 40'h0023450000});

      rst = 1'b1;
      drive(C_IDLE, 4'd0, 32'd0, 64'd0, 1'b0);
      do_reset();
      #1;
      check("reset data", 64'(packed_data()), 64'd0);
      check("reset alloc_valid", 64'(valid_allocation_id), 64'd0);
      check("reset alloc_id", 64'(allocation_id), 64'd0);
      check("reset valid_data", 64'(valid_data_out), 64'd0);

      run_vecs(0, 3);

      // 6000 increments of the 12-bit counter at id 0 -> 6000 mod 4096 = 0x770
      @(negedge clk);
      drive(C_INC, 4'd0, 32'd0, 64'd0, 1'b0);
      repeat (6000) @(posedge clk);
      #1;
      check("inc6000 data", 64'(packed_data()), 64'h770);
      @(negedge clk);
      drive(C_IDLE, 4'd0, 32'd0, 64'd0, 1'b0);

      // read held for 5 cycles: exactly three valid slices
      rd_exp[0] = 4'h0; rd_exp[1] = 4'h7; rd_exp[2] = 4'h7; rd_exp[3] = 4'h0; rd_exp[4] = 4'h0;
      @(negedge clk);
      drive(C_RD, 4'd0, 32'd0, 64'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("read c%0d valid", k), 64'(valid_data_out), 64'(k < 3));
         check($sformatf("read c%0d rdata", k), 64'(rdata_out), 64'(rd_exp[k]));
         check($sformatf("read c%0d last", k), 64'(last), 64'(k == 2));
      end
      @(negedge clk);
      drive(C_IDLE, 4'd0, 32'd0, 64'd0, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("read after drop valid", 64'(valid_data_out), 64'd0);
      end

      // read of a non-head is ignored
      @(negedge clk);
      drive(C_RD, 4'd1, 32'd0, 64'd0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(C_IDLE, 4'd0, 32'd0, 64'd0, 1'b0);
      #1;
      check("read non-head valid", 64'(valid_data_out), 64'd0);

      run_vecs(4, vecs.size() - 1);

      // ten single-slice counters, then increment ids 0..7 back to back
      do_reset();
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         drive(C_NEW, 4'd0, 32'd1, 64'd0, 1'b0);
         @(posedge clk);
         #1;
         check($sformatf("alloc1 #%0d", i), 64'(allocation_id), 64'(i));
         check($sformatf("alloc1 #%0d valid", i), 64'(valid_allocation_id), 64'd1);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(C_INC, 4'(i), 32'd0, 64'd0, 1'b0);
      end
      @(negedge clk);
      drive(C_IDLE, 4'd0, 32'd0, 64'd0, 1'b0);
      #1;
      check("inc ids 0-7 data", 64'(packed_data()), 64'h0011111111);

      // reset asserted while a read is streaming
      do_reset();
      @(negedge clk);
      drive(C_NEW, 4'd0, 32'd5, 64'd0, 1'b0);
      @(negedge clk);
      drive(C_LD, 4'd0, 32'd0, 64'h12345, 1'b1);
      @(negedge clk);
      drive(C_RD, 4'd0, 32'd0, 64'd0, 1'b0);
      @(posedge clk);
      #1;
      check("midread valid", 64'(valid_data_out), 64'd1);
      check("midread rdata", 64'(rdata_out), 64'h5);
      @(negedge clk);
      rst = 1'b1;
      drive(C_IDLE, 4'd0, 32'd0, 64'd0, 1'b0);
      @(posedge clk);
      #1;
      check("rst midread valid", 64'(valid_data_out), 64'd0);
      check("rst midread rdata", 64'(rdata_out), 64'd0);
      check("rst midread last", 64'(last), 64'd0);
      check("rst midread data", 64'(packed_data()), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
